snoop_responder: RTL and testbench

Per-cache snoop agent for the MSI snooping coherence protocol: the receiving end of bus transactions issued by the requesting-processor controller. Holds one cache's tag/state/data arrays and accepts one bus message at a time (write miss, read miss, invalidate). Performs the MSI receiver transitions and, for a Modified hit, requests a write-back of the dirty line to memory over a req/ack handshake before acknowledging. One instance per processor on the shared bus.

---
 rtl/snoop_responder.sv | 206 ++++++++++++++++++++
 tb/tb_snoop_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_responder.sv
// -----------------------------------------------------------------------------
// snoop_responder
//
// Per-cache snoop agent for an MSI snooping coherence protocol. Holds one
// direct-mapped cache's tag/state/data arrays and services one bus message at
// a time (write miss, read miss, invalidate). A snoop hit on a Modified line
// (read or write miss) writes the dirty line back to memory over a req/ack
// handshake before the message is acknowledged.
//
// Ports
//   clock, resetn           : rising-edge clock, asynchronous active-low reset
//   bus_valid/bus_ready     : bus message handshake (transfer on both high)
//   bus_msg/src/tag/index   : message type, issuing CPU, address tag, line index
//   snoop_done/hit/flush    : one-cycle completion pulse with hit / write-back
//   wb_req/tag/data, wb_ack : write-back request to memory and its acceptance
//   loc_ready, loc_we, loc_*: local install/update port (only in IDLE)
//   rd_index, rd_*          : combinational line readout
//   proto_err               : sticky, invalidate seen for a Modified line
// -----------------------------------------------------------------------------
module snoop_responder #(
  parameter int MY_ID  = 0,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 2
) (
  input  logic              clock,
  input  logic              resetn,
  // bus message port
  input  logic              bus_valid,
  output logic              bus_ready,
  input  logic [1:0]        bus_msg,
  input  logic [1:0]        bus_src,
  input  logic [TAG_W-1:0]  bus_tag,
  input  logic [IDX_W-1:0]  bus_index,
  // completion
  output logic              snoop_done,
  output logic              snoop_hit,
  output logic              snoop_flush,
  // write-back to memory
  output logic              wb_req,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ack,
  // local write port
  output logic              loc_ready,
  input  logic              loc_we,
  input  logic [IDX_W-1:0]  loc_index,
  input  logic [TAG_W-1:0]  loc_tag,
  input  logic [1:0]        loc_state,
  input  logic [DATA_W-1:0] loc_data,
  // readout
  input  logic [IDX_W-1:0]  rd_index,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [1:0]        rd_state,
  output logic [DATA_W-1:0] rd_data,
  // sticky protocol error
  output logic              proto_err
);

  localparam int LINES = 1 << IDX_W;

  // Line coherence states; 2'b11 is never stored.
  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  // Bus message encodings.
  localparam logic [1:0] MSG_WRITE_MISS = 2'b00;
  localparam logic [1:0] MSG_READ_MISS  = 2'b01;
  localparam logic [1:0] MSG_INVALIDATE = 2'b10;
  localparam logic [1:0] MSG_NA         = 2'b11;

  localparam logic [1:0] MY_SRC = MY_ID[1:0];

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOOKUP  = 2'b01,
    WB_WAIT = 2'b10,
    DONE    = 2'b11
  } fsm_t;

  fsm_t fsm;

  logic [TAG_W-1:0]  tag_mem   [LINES];
  logic [1:0]        state_mem [LINES];
  logic [DATA_W-1:0] data_mem  [LINES];

  // Captured message, stable for the whole transaction.
  logic [1:0]       cap_msg;
  logic [1:0]       cap_src;
  logic [TAG_W-1:0] cap_tag;
  logic [IDX_W-1:0] cap_index;

  logic lookup_hit;

  // Local writes win over bus messages in the same IDLE cycle.
  assign bus_ready = (fsm == IDLE) && !loc_we;
  assign loc_ready = (fsm == IDLE);

  assign rd_tag   = tag_mem[rd_index];
  assign rd_state = state_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

  assign lookup_hit = (cap_src != MY_SRC) && (cap_msg != MSG_NA) &&
                      (tag_mem[cap_index] == cap_tag) &&
                      (state_mem[cap_index] != ST_I);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, regardless of statement order inside the block.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fsm         <= IDLE;
      cap_msg     <= MSG_WRITE_MISS;
      cap_src     <= '0;
      cap_tag     <= '0;
      cap_index   <= '0;
      snoop_done  <= 1'b0;
      snoop_hit   <= 1'b0;
      snoop_flush <= 1'b0;
      wb_req      <= 1'b0;
      wb_tag      <= '0;
      wb_data     <= '0;
      proto_err   <= 1'b0;
      // NOTE: the line arrays are tiny register files whose reset contents
      // (all lines Invalid) are architecturally visible, so they are reset
      // here rather than mapped to an unresettable RAM.
      for (int i = 0; i < LINES; i++) begin
        tag_mem[i]   <= '0;
        state_mem[i] <= ST_I;
        data_mem[i]  <= '0;
      end
    end else begin
      case (fsm)
        IDLE: begin
          if (loc_we) begin
            tag_mem[loc_index]   <= loc_tag;
            data_mem[loc_index]  <= loc_data;
            // The unused encoding is folded to Invalid on install.
            state_mem[loc_index] <= (loc_state == 2'b11) ? ST_I : loc_state;
          end else if (bus_valid) begin
            cap_msg   <= bus_msg;
            cap_src   <= bus_src;
            cap_tag   <= bus_tag;
            cap_index <= bus_index;
            fsm       <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (!lookup_hit) begin
            snoop_hit   <= 1'b0;
            snoop_flush <= 1'b0;
            snoop_done  <= 1'b1;
            fsm         <= DONE;
          end else if (state_mem[cap_index] == ST_M) begin
            if (cap_msg == MSG_INVALIDATE) begin
              // Another cache cannot legally upgrade while we own the line
              // dirty; record it, drop the line, but do not write it back.
              state_mem[cap_index] <= ST_I;
              proto_err            <= 1'b1;
              snoop_hit            <= 1'b1;
              snoop_flush          <= 1'b0;
              snoop_done           <= 1'b1;
              fsm                  <= DONE;
            end else begin
              wb_req  <= 1'b1;
              wb_tag  <= tag_mem[cap_index];
              wb_data <= data_mem[cap_index];
              fsm     <= WB_WAIT;
            end
          end else begin
            // Shared hit: read miss keeps the copy, anything else drops it.
            if (cap_msg != MSG_READ_MISS) begin
              state_mem[cap_index] <= ST_I;
            end
            snoop_hit   <= 1'b1;
            snoop_flush <= 1'b0;
            snoop_done  <= 1'b1;
            fsm         <= DONE;
          end
        end

        WB_WAIT: begin
          if (wb_ack) begin
            wb_req               <= 1'b0;
            state_mem[cap_index] <= (cap_msg == MSG_READ_MISS) ? ST_S : ST_I;
            snoop_hit            <= 1'b1;
            snoop_flush          <= 1'b1;
            snoop_done           <= 1'b1;
            fsm                  <= DONE;
          end
        end

        DONE: begin
          snoop_done  <= 1'b0;
          snoop_hit   <= 1'b0;
          snoop_flush <= 1'b0;
          fsm         <= IDLE;
        end

        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_responder.sv
// -----------------------------------------------------------------------------
// tb_snoop_responder
//
// Directed, table-driven bench for snoop_responder. Each table row installs a
// line through the local port, issues one bus message, and checks completion
// latency, hit/flush, write-back contents and the resulting line. Hand-written
// sequences cover the protocol error, local/bus collision and reset during a
// write-back. The DUT uses MY_ID = 3 so that sources 0..2 are foreign caches.
// -----------------------------------------------------------------------------
module tb_snoop_responder;

  localparam int MY_ID  = 3;
  localparam int TAG_W  = 3;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 2;

  localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_M = 2'b10;
  localparam logic [1:0] WM = 2'b00, RM = 2'b01, INV = 2'b10, NA = 2'b11;

  logic              clock;
  logic              resetn;
  logic              bus_valid;
  logic              bus_ready;
  logic [1:0]        bus_msg;
  logic [1:0]        bus_src;
  logic [TAG_W-1:0]  bus_tag;
  logic [IDX_W-1:0]  bus_index;
  logic              snoop_done;
  logic              snoop_hit;
  logic              snoop_flush;
  logic              wb_req;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ack;
  logic              loc_ready;
  logic              loc_we;
  logic [IDX_W-1:0]  loc_index;
  logic [TAG_W-1:0]  loc_tag;
  logic [1:0]        loc_state;
  logic [DATA_W-1:0] loc_data;
  logic [IDX_W-1:0]  rd_index;
  logic [TAG_W-1:0]  rd_tag;
  logic [1:0]        rd_state;
  logic [DATA_W-1:0] rd_data;
  logic              proto_err;

  snoop_responder #(
    .MY_ID(MY_ID), .TAG_W(TAG_W), .DATA_W(DATA_W), .IDX_W(IDX_W)
  ) dut (
    .clock(clock), .resetn(resetn),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_msg(bus_msg),
    .bus_src(bus_src), .bus_tag(bus_tag), .bus_index(bus_index),
    .snoop_done(snoop_done), .snoop_hit(snoop_hit), .snoop_flush(snoop_flush),
    .wb_req(wb_req), .wb_tag(wb_tag), .wb_data(wb_data), .wb_ack(wb_ack),
    .loc_ready(loc_ready), .loc_we(loc_we), .loc_index(loc_index),
    .loc_tag(loc_tag), .loc_state(loc_state), .loc_data(loc_data),
    .rd_index(rd_index), .rd_tag(rd_tag), .rd_state(rd_state),
    .rd_data(rd_data), .proto_err(proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Results of the last wait_done.
  int                r_done_cyc;
  logic              r_hit;
  logic              r_flush;
  logic              r_saw_wb;
  logic              r_wb_stable;
  logic [TAG_W-1:0]  r_wb_tag;
  logic [DATA_W-1:0] r_wb_data;

  // Entered 1 time unit after the accepting edge (cycle 1). Acks the
  // write-back in its (ack_delay+1)-th request cycle, records the cycle in
  // which snoop_done is seen, then steps into the following IDLE cycle.
  task automatic wait_done(input int ack_delay);
    int cyc = 1;
    int wbc = 0;
    r_done_cyc  = -1;
    r_hit       = 1'bx;
    r_flush     = 1'bx;
    r_saw_wb    = 1'b0;
    r_wb_stable = 1'b1;
    r_wb_tag    = '0;
    r_wb_data   = '0;
    while (cyc < 40) begin
      if (snoop_done === 1'b1) begin
        r_done_cyc = cyc;
        r_hit      = snoop_hit;
        r_flush    = snoop_flush;
        break;
      end
      if (wb_req === 1'b1) begin
        if (!r_saw_wb) begin
          r_wb_tag  = wb_tag;
          r_wb_data = wb_data;
        end else if (wb_tag !== r_wb_tag || wb_data !== r_wb_data) begin
          r_wb_stable = 1'b0;
        end
        r_saw_wb = 1'b1;
        wb_ack   = (wbc == ack_delay);
        wbc++;
      end
      @(posedge clock); #1;
      wb_ack = 1'b0;
      cyc++;
    end
    @(posedge clock); #1;
  endtask

  task automatic loc_write(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                           input logic [1:0] st, input logic [DATA_W-1:0] data);
    loc_we = 1'b1; loc_index = idx; loc_tag = tag; loc_state = st; loc_data = data;
    @(posedge clock); #1;
    loc_we = 1'b0;
  endtask

  task automatic run_msg(input logic [1:0] msg, input logic [1:0] src,
                         input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx,
                         input int ack_delay);
    bus_valid = 1'b1; bus_msg = msg; bus_src = src; bus_tag = tag; bus_index = idx;
    @(posedge clock); #1;
    bus_valid = 1'b0;
    wait_done(ack_delay);
  endtask

  typedef struct {
    logic [IDX_W-1:0]  l_idx;
    logic [TAG_W-1:0]  l_tag;
    logic [1:0]        l_st;
    logic [DATA_W-1:0] l_data;
    logic [1:0]        msg;
    logic [1:0]        src;
    logic [TAG_W-1:0]  tag;
    int                ack_delay;
    logic              e_hit;
    logic              e_flush;
    int                e_done;
    logic [1:0]        e_state;
  } vec_t;

  vec_t vecs[9];

  initial begin
    resetn = 1'b0; bus_valid = 1'b0; bus_msg = '0; bus_src = '0; bus_tag = '0;
    bus_index = '0; wb_ack = 1'b0; loc_we = 1'b0; loc_index = '0; loc_tag = '0;
    loc_state = '0; loc_data = '0; rd_index = '0;

    // Every message targets the line the row just installed (bus_index = l_idx).
    //          idx   tag   st     data      msg  src  tag  ack hit flush done state
    vecs[0] = '{2'd1, 3'd1, ST_M, 16'd30,   RM,  2'd0, 3'd1, 3, 1'b1, 1'b1, 6, ST_S};
    vecs[1] = '{2'd0, 3'd0, ST_S, 16'h1111, WM,  2'd2, 3'd0, 0, 1'b1, 1'b0, 2, ST_I};
    vecs[2] = '{2'd2, 3'd2, ST_S, 16'h2222, INV, 2'd1, 3'd3, 0, 1'b0, 1'b0, 2, ST_S};
    vecs[3] = '{2'd2, 3'd2, ST_S, 16'h2222, INV, 2'd3, 3'd2, 0, 1'b0, 1'b0, 2, ST_S};
    vecs[4] = '{2'd3, 3'd5, ST_S, 16'h0055, RM,  2'd1, 3'd5, 0, 1'b1, 1'b0, 2, ST_S};
    vecs[5] = '{2'd3, 3'd6, ST_M, 16'habcd, WM,  2'd2, 3'd6, 0, 1'b1, 1'b1, 3, ST_I};
    vecs[6] = '{2'd0, 3'd4, ST_I, 16'h0044, RM,  2'd0, 3'd4, 0, 1'b0, 1'b0, 2, ST_I};
    vecs[7] = '{2'd1, 3'd7, 2'b11, 16'h0077, RM, 2'd1, 3'd7, 0, 1'b0, 1'b0, 2, ST_I};
    vecs[8] = '{2'd2, 3'd1, ST_M, 16'h0099, NA,  2'd0, 3'd1, 0, 1'b0, 1'b0, 2, ST_M};

    #12;
    check("rst bus_ready", bus_ready, 1);
    check("rst loc_ready", loc_ready, 1);
    check("rst outputs", {snoop_done, snoop_hit, snoop_flush, wb_req, proto_err}, 0);
    check("rst wb_tag_data", {wb_tag, wb_data}, 0);
    for (int i = 0; i < 4; i++) begin
      rd_index = i[IDX_W-1:0]; #1;
      check($sformatf("rst line%0d", i), {rd_tag, rd_state, rd_data}, 0);
    end
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;

    for (int v = 0; v < 9; v++) begin
      loc_write(vecs[v].l_idx, vecs[v].l_tag, vecs[v].l_st, vecs[v].l_data);
      run_msg(vecs[v].msg, vecs[v].src, vecs[v].tag, vecs[v].l_idx, vecs[v].ack_delay);
      check($sformatf("v%0d done_cycle", v), r_done_cyc, vecs[v].e_done);
      check($sformatf("v%0d hit", v), r_hit, vecs[v].e_hit);
      check($sformatf("v%0d flush", v), r_flush, vecs[v].e_flush);
      check($sformatf("v%0d wb_seen", v), r_saw_wb, vecs[v].e_flush);
      if (vecs[v].e_flush) begin
        check($sformatf("v%0d wb_tag", v), r_wb_tag, vecs[v].l_tag);
        check($sformatf("v%0d wb_data", v), r_wb_data, vecs[v].l_data);
        check($sformatf("v%0d wb_stable", v), r_wb_stable, 1);
      end
      rd_index = vecs[v].l_idx; #1;
      check($sformatf("v%0d state", v), rd_state, vecs[v].e_state);
      check($sformatf("v%0d tag", v), rd_tag, vecs[v].l_tag);
      check($sformatf("v%0d data", v), rd_data, vecs[v].l_data);
    end
    check("no proto_err yet", proto_err, 0);

    // Invalidate against a Modified line: error, drop, no write-back.
    loc_write(2'd1, 3'd2, ST_M, 16'h1234);
    run_msg(INV, 2'd1, 3'd2, 2'd1, 0);
    check("perr done_cycle", r_done_cyc, 2);
    check("perr hit", r_hit, 1);
    check("perr flush", r_flush, 0);
    check("perr wb_seen", r_saw_wb, 0);
    check("perr set", proto_err, 1);
    rd_index = 2'd1; #1;
    check("perr state", rd_state, ST_I);
    run_msg(RM, 2'd2, 3'd5, 2'd3, 0);
    check("perr miss hit", r_hit, 0);
    check("perr sticky", proto_err, 1);

    // Local write and bus message in the same IDLE cycle.
    loc_we = 1'b1; loc_index = 2'd0; loc_tag = 3'd3; loc_state = ST_S; loc_data = 16'h0303;
    bus_valid = 1'b1; bus_msg = RM; bus_src = 2'd1; bus_tag = 3'd3; bus_index = 2'd0;
    #1;
    check("coll bus_ready", bus_ready, 0);
    check("coll loc_ready", loc_ready, 1);
    @(posedge clock); #1;
    loc_we = 1'b0; #1;
    check("coll bus_ready next", bus_ready, 1);
    rd_index = 2'd0; #1;
    check("coll write landed", {rd_tag, rd_state}, {3'd3, ST_S});
    @(posedge clock); #1;
    bus_valid = 1'b0;
    check("lookup loc_ready", loc_ready, 0);
    check("lookup bus_ready", bus_ready, 0);
    // This write must be ignored outside IDLE.
    loc_we = 1'b1; loc_index = 2'd2; loc_tag = 3'd0; loc_state = ST_S; loc_data = 16'hffff;
    @(posedge clock); #1;
    loc_we = 1'b0;
    check("coll done", snoop_done, 1);
    check("coll hit", snoop_hit, 1);
    check("coll flush", snoop_flush, 0);
    @(posedge clock); #1;
    rd_index = 2'd2; #1;
    check("ignored loc_we", {rd_tag, rd_state, rd_data}, {3'd1, ST_M, 16'h0099});

    // Reset while a write-back is pending.
    loc_write(2'd3, 3'd1, ST_M, 16'h4242);
    bus_valid = 1'b1; bus_msg = WM; bus_src = 2'd2; bus_tag = 3'd1; bus_index = 2'd3;
    @(posedge clock); #1;
    bus_valid = 1'b0;
    @(posedge clock); #1;
    check("mid wb_req", wb_req, 1);
    #2 resetn = 1'b0;
    #1;
    check("async wb_req drop", wb_req, 0);
    check("async ready", {bus_ready, loc_ready}, 2'b11);
    check("async done", snoop_done, 0);
    for (int i = 0; i < 4; i++) begin
      rd_index = i[IDX_W-1:0]; #1;
      check($sformatf("async line%0d", i), {rd_tag, rd_state, rd_data}, 0);
    end
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
